// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//   Multi-cycle sequencer for the add/sub datapath. Each instruction walks
//   FETCH -> DECODE -> EXECUTE -> WRITEBACK. FETCH waits for instruction
//   memory to report a valid word. The block drives the datapath write
//   strobes, the operand/destination muxes and the ALU operation select.
//   Mux and ALU selects stay stable for the whole of each phase.
//
// Optional feature (compile-time macro OVERFLOW_TRAP_EN):
//   When defined, a signed overflow on an ADD/SUB op suppresses the register
//   write, sets a sticky trap flag and parks the FSM in HALT until Reset.
//   When undefined, alu_overflow is ignored, and neither the trap port nor
//   the HALT state exists.
//
// Parameters:
//   CNT_W        width of the retired-instruction counter (wraps, no saturate)
//
// Ports:
//   CLK          in   1      system clock, rising edge
//   Reset        in   1      synchronous active-high reset
//   imem_ready   in   1      instruction word valid on the IR input this cycle
//   opcode       in   6      IR[31:26], valid from DECODE onward
//   funct        in   6      IR[5:0], valid from DECODE onward
//   alu_overflow in   1      ALU signed-overflow flag, sampled in EXECUTE
//   ir_write     out  1      load IR (1-cycle pulse in FETCH)
//   pc_write     out  1      PC <= PC+4 (1-cycle pulse in WRITEBACK)
//   alu_src_b    out  1      0 = rt, 1 = sign-extended imm16
//   reg_dst      out  1      0 = rd, 1 = rt destination
//   reg_write    out  1      register-file write enable (1-cycle pulse)
//   alu_op       out  4      ALU operation select (NOP/ADD/ADDU/SUB/SUBU)
//   busy         out  1      high in every state except FETCH
//   retired      out  CNT_W  number of completed instructions
//   trap         out  1      sticky overflow trap (OVERFLOW_TRAP_EN only)
//
// ALU operation encodings on alu_op:
//   4'd0 NOP, 4'd1 ADD, 4'd2 ADDU, 4'd3 SUB, 4'd4 SUBU
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             imem_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_overflow,
  output logic             ir_write,
  output logic             pc_write,
  output logic             alu_src_b,
  output logic             reg_dst,
  output logic             reg_write,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic [CNT_W-1:0] retired
`ifdef OVERFLOW_TRAP_EN
  ,
  output logic             trap
`endif
);

  // ALU operation encodings
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_ADDU = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SUBU = 4'd4;

  // Instruction fields recognised by the decoder
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUB    = 6'h22;
  localparam logic [5:0] FN_SUBU   = 6'h23;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
`ifdef OVERFLOW_TRAP_EN
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
`else
    ST_WRITEBACK = 3'd3
`endif
  } state_t;

  // Decoder result: {legal, alu_src_b, reg_dst, alu_op}
  typedef struct packed {
    logic       legal;
    logic       src_b;
    logic       dst;
    logic [3:0] op;
  } dec_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [3:0]       alu_op_r;
  logic [3:0]       alu_op_next_s;
  logic             alu_src_b_r;
  logic             alu_src_b_next_s;
  logic             reg_dst_r;
  logic             reg_dst_next_s;
  logic             legal_r;
  logic             legal_next_s;
  logic             pc_write_r;
  logic             pc_write_next_s;
  logic             reg_write_r;
  logic             reg_write_next_s;
  logic             busy_r;
  logic             busy_next_s;
  logic [CNT_W-1:0] retired_r;
  logic [CNT_W-1:0] retired_next_s;
  dec_t             dec_s;

`ifdef OVERFLOW_TRAP_EN
  logic             ovf_r;
  logic             ovf_next_s;
  logic             trap_r;
  logic             trap_next_s;
  logic             ovf_now_s;
`else
  // Overflow has no effect in this build; keep the port visibly consumed.
  logic             unused_ovf_s;
  assign unused_ovf_s = alu_overflow;
`endif

  // Translate opcode/funct into ALU select, mux settings and legality.
  function automatic dec_t decode_instr(input logic [5:0] op_in, input logic [5:0] fn_in);
    dec_t d;
    d = '{legal: 1'b0, src_b: 1'b0, dst: 1'b0, op: ALU_NOP};
    case (op_in)
      OPC_RTYPE: begin
        case (fn_in)
          FN_ADD:  d = '{legal: 1'b1, src_b: 1'b0, dst: 1'b0, op: ALU_ADD};
          FN_ADDU: d = '{legal: 1'b1, src_b: 1'b0, dst: 1'b0, op: ALU_ADDU};
          FN_SUB:  d = '{legal: 1'b1, src_b: 1'b0, dst: 1'b0, op: ALU_SUB};
          FN_SUBU: d = '{legal: 1'b1, src_b: 1'b0, dst: 1'b0, op: ALU_SUBU};
          default: d = '{legal: 1'b0, src_b: 1'b0, dst: 1'b0, op: ALU_NOP};
        endcase
      end
      OPC_ADDI:  d = '{legal: 1'b1, src_b: 1'b1, dst: 1'b1, op: ALU_ADD};
      OPC_ADDIU: d = '{legal: 1'b1, src_b: 1'b1, dst: 1'b1, op: ALU_ADDU};
      default:   d = '{legal: 1'b0, src_b: 1'b0, dst: 1'b0, op: ALU_NOP};
    endcase
    return d;
  endfunction

  // Combinational instruction decode from the live IR fields.
  always_comb begin
    dec_s = decode_instr(opcode, funct);
  end

`ifdef OVERFLOW_TRAP_EN
  // Only the trapping (signed) ops care about overflow.
  always_comb begin
    ovf_now_s = alu_overflow && ((alu_op_r == ALU_ADD) || (alu_op_r == ALU_SUB));
  end
`endif

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    next_state_s     = state_r;
    alu_op_next_s    = alu_op_r;
    alu_src_b_next_s = alu_src_b_r;
    reg_dst_next_s   = reg_dst_r;
    legal_next_s     = legal_r;
    pc_write_next_s  = 1'b0;
    reg_write_next_s = 1'b0;
    busy_next_s      = busy_r;
    retired_next_s   = retired_r;
`ifdef OVERFLOW_TRAP_EN
    ovf_next_s       = ovf_r;
    trap_next_s      = trap_r;
`endif
    case (state_r)
      ST_FETCH: begin
        if (imem_ready) begin
          next_state_s = ST_DECODE;
          busy_next_s  = 1'b1;
        end else begin
          next_state_s = ST_FETCH;
          busy_next_s  = 1'b0;
        end
      end
      ST_DECODE: begin
        // Decode results are latched here and held through WRITEBACK.
        next_state_s     = ST_EXECUTE;
        alu_op_next_s    = dec_s.op;
        alu_src_b_next_s = dec_s.src_b;
        reg_dst_next_s   = dec_s.dst;
        legal_next_s     = dec_s.legal;
      end
      ST_EXECUTE: begin
        // Strobes are registered, so they are set up one cycle ahead of WRITEBACK.
        next_state_s    = ST_WRITEBACK;
        pc_write_next_s = 1'b1;
`ifdef OVERFLOW_TRAP_EN
        ovf_next_s       = ovf_now_s;
        reg_write_next_s = legal_r && !ovf_now_s;
`else
        reg_write_next_s = legal_r;
`endif
      end
      ST_WRITEBACK: begin
        alu_op_next_s    = ALU_NOP;
        alu_src_b_next_s = 1'b0;
        reg_dst_next_s   = 1'b0;
        legal_next_s     = 1'b0;
`ifdef OVERFLOW_TRAP_EN
        if (ovf_r) begin
          next_state_s = ST_HALT;
          busy_next_s  = 1'b1;
          trap_next_s  = 1'b1;
          ovf_next_s   = 1'b0;
        end else begin
          next_state_s   = ST_FETCH;
          busy_next_s    = 1'b0;
          retired_next_s = retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
`else
        next_state_s   = ST_FETCH;
        busy_next_s    = 1'b0;
        retired_next_s = retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
      end
`ifdef OVERFLOW_TRAP_EN
      ST_HALT: begin
        // Parked until Reset; everything else is ignored.
        next_state_s = ST_HALT;
        busy_next_s  = 1'b1;
      end
`endif
      default: begin
        // Unreachable encodings recover to an idle FETCH.
        next_state_s     = ST_FETCH;
        alu_op_next_s    = ALU_NOP;
        alu_src_b_next_s = 1'b0;
        reg_dst_next_s   = 1'b0;
        legal_next_s     = 1'b0;
        busy_next_s      = 1'b0;
      end
    endcase
  end

  // State and registered outputs; Reset overrides any in-flight instruction.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r     <= ST_FETCH;
      alu_op_r    <= ALU_NOP;
      alu_src_b_r <= 1'b0;
      reg_dst_r   <= 1'b0;
      legal_r     <= 1'b0;
      pc_write_r  <= 1'b0;
      reg_write_r <= 1'b0;
      busy_r      <= 1'b0;
      retired_r   <= {CNT_W{1'b0}};
`ifdef OVERFLOW_TRAP_EN
      ovf_r       <= 1'b0;
      trap_r      <= 1'b0;
`endif
    end else begin
      state_r     <= next_state_s;
      alu_op_r    <= alu_op_next_s;
      alu_src_b_r <= alu_src_b_next_s;
      reg_dst_r   <= reg_dst_next_s;
      legal_r     <= legal_next_s;
      pc_write_r  <= pc_write_next_s;
      reg_write_r <= reg_write_next_s;
      busy_r      <= busy_next_s;
      retired_r   <= retired_next_s;
`ifdef OVERFLOW_TRAP_EN
      ovf_r       <= ovf_next_s;
      trap_r      <= trap_next_s;
`endif
    end
  end

  // ir_write must coincide with imem_ready, so it is decoded from the state.
  // All write strobes are masked while Reset is high so that no write can
  // escape in the reset cycle itself.
  assign ir_write  = (state_r == ST_FETCH) && imem_ready && !Reset;
  assign pc_write  = pc_write_r && !Reset;
  assign reg_write = reg_write_r && !Reset;
  assign alu_op    = alu_op_r;
  assign alu_src_b = alu_src_b_r;
  assign reg_dst   = reg_dst_r;
  assign busy      = busy_r;
  assign retired   = retired_r;
`ifdef OVERFLOW_TRAP_EN
  assign trap      = trap_r;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control. Each instruction is described by
// opcode/funct/stall/overflow. The expected per-cycle outputs come from a
// table-driven instruction model plus the documented phase timing. Define
// OVERFLOW_TRAP_EN for both the bench and the RTL to exercise the trap build.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int CNT_W = 32;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDU = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SUBU = 4'd4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             imem_ready;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_overflow;
  logic             ir_write;
  logic             pc_write;
  logic             alu_src_b;
  logic             reg_dst;
  logic             reg_write;
  logic [3:0]       alu_op;
  logic             busy;
  logic [CNT_W-1:0] retired;
`ifdef OVERFLOW_TRAP_EN
  logic             trap;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Model state: instructions completed since the last reset, sticky trap.
  logic [CNT_W-1:0] exp_retired = '0;
  logic             exp_trap    = 1'b0;

  always #5 CLK = ~CLK;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .imem_ready   (imem_ready),
    .opcode       (opcode),
    .funct        (funct),
    .alu_overflow (alu_overflow),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .alu_src_b    (alu_src_b),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_op       (alu_op),
    .busy         (busy),
    .retired      (retired)
`ifdef OVERFLOW_TRAP_EN
    ,
    .trap         (trap)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares {ir,pc,rw,busy,src_b,dst,alu_op}, retired and (trap build) trap.
  task automatic check_outs(input string tag, input logic e_ir, input logic e_pc,
                            input logic e_rw, input logic e_busy, input logic e_srcb,
                            input logic e_dst, input logic [3:0] e_op);
    check({tag, ".outs"}, {ir_write, pc_write, reg_write, busy, alu_src_b, reg_dst, alu_op},
          {e_ir, e_pc, e_rw, e_busy, e_srcb, e_dst, e_op});
    check({tag, ".retired"}, retired, exp_retired);
`ifdef OVERFLOW_TRAP_EN
    check({tag, ".trap"}, trap, exp_trap);
`endif
  endtask

  // Reference instruction table.
  task automatic ref_decode(input logic [5:0] op, input logic [5:0] fn,
                            output logic [3:0] aop, output logic srcb,
                            output logic dst, output logic legal);
    aop = OP_NOP; srcb = 1'b0; dst = 1'b0; legal = 1'b0;
    if (op == 6'h00 && fn == 6'h20)      begin aop = OP_ADD;  legal = 1'b1; end
    else if (op == 6'h00 && fn == 6'h21) begin aop = OP_ADDU; legal = 1'b1; end
    else if (op == 6'h00 && fn == 6'h22) begin aop = OP_SUB;  legal = 1'b1; end
    else if (op == 6'h00 && fn == 6'h23) begin aop = OP_SUBU; legal = 1'b1; end
    else if (op == 6'h08) begin aop = OP_ADD;  srcb = 1'b1; dst = 1'b1; legal = 1'b1; end
    else if (op == 6'h09) begin aop = OP_ADDU; srcb = 1'b1; dst = 1'b1; legal = 1'b1; end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called with Reset about to be raised for the current cycle: checks that no
  // strobe escapes in the reset cycle, then the reset values one cycle later.
  task automatic reset_seq(input string tag);
    Reset = 1'b1;
    #1;
    check({tag, ".rst_cycle_strobes"}, {ir_write, pc_write, reg_write}, 3'b000);
    tick();
    Reset = 1'b0;
    imem_ready = 1'b0;
    #1;
    exp_retired = '0;
    exp_trap    = 1'b0;
    check_outs({tag, ".after_rst"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OP_NOP);
  endtask

  // One instruction: stall cycles, then FETCH/DECODE/EXECUTE/WRITEBACK.
  // rst_phase 1..4 raises Reset in that phase instead of completing.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int stall, input logic ovf, input int rst_phase);
    logic [3:0] aop;
    logic srcb, dst, legal, trapping;
    ref_decode(op, fn, aop, srcb, dst, legal);
    trapping = 1'b0;
`ifdef OVERFLOW_TRAP_EN
    trapping = ovf && (aop == OP_ADD || aop == OP_SUB);
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      imem_ready = 1'b0;
      opcode = 6'($urandom); funct = 6'($urandom); alu_overflow = 1'($urandom);
      #1;
      check_outs({tag, ".stall"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OP_NOP);
    end
    for (int p = 1; p <= 4; p++) begin
      tick();
      imem_ready   = (p == 1) ? 1'b1 : 1'($urandom);
      opcode       = (p == 1) ? 6'($urandom) : op;
      funct        = (p == 1) ? 6'($urandom) : fn;
      alu_overflow = (p == 3) ? ovf : 1'($urandom);
      if (p == rst_phase) begin
        reset_seq({tag, ".midrst"});
        return;
      end
      #1;
      case (p)
        1: check_outs({tag, ".fetch"},  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OP_NOP);
        2: check_outs({tag, ".decode"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, OP_NOP);
        3: check_outs({tag, ".exec"},   1'b0, 1'b0, 1'b0, 1'b1, srcb, dst, aop);
        default: check_outs({tag, ".wb"}, 1'b0, 1'b1, legal && !trapping, 1'b1, srcb, dst, aop);
      endcase
    end
    if (trapping) begin
      exp_trap = 1'b1;
      for (int h = 0; h < 3; h++) begin
        tick();
        imem_ready = 1'b1; alu_overflow = 1'($urandom);
        #1;
        check_outs({tag, ".halt"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, OP_NOP);
      end
      tick();
      reset_seq({tag, ".halt_exit"});
    end else begin
      exp_retired = exp_retired + 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [5:0] r_op, r_fn;
    int sel;
    // Reset with imem_ready high: ir_write must stay low in the reset cycle.
    imem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; alu_overflow = 1'b0;
    reset_seq("init");

    run_instr("r_add",     6'h00, 6'h20, 0, 1'b0, 0);
    run_instr("addiu",     6'h09, 6'h00, 0, 1'b0, 0);
    run_instr("stall_sub", 6'h00, 6'h22, 5, 1'b0, 0);
    run_instr("nop_op23",  6'h23, 6'h20, 0, 1'b0, 0);
    run_instr("subu",      6'h00, 6'h23, 1, 1'b0, 0);
    run_instr("addu_ovf",  6'h00, 6'h21, 0, 1'b1, 0);
    run_instr("addi",      6'h08, 6'h3f, 2, 1'b0, 0);
    run_instr("rst_exec",  6'h00, 6'h20, 0, 1'b0, 3);
    run_instr("post_rst",  6'h09, 6'h11, 2, 1'b0, 0);
    run_instr("rst_wb",    6'h08, 6'h00, 0, 1'b0, 4);
    run_instr("rst_fetch", 6'h00, 6'h21, 0, 1'b0, 1);
    run_instr("rst_dec",   6'h00, 6'h22, 1, 1'b0, 2);
    run_instr("add_ovf",   6'h00, 6'h20, 0, 1'b1, 0);
    run_instr("addi_ovf",  6'h08, 6'h00, 1, 1'b1, 0);
    run_instr("sub_ok",    6'h00, 6'h22, 0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1, 2, 3: begin r_op = 6'h00; r_fn = 6'(6'h20 + sel); end
        4:          begin r_op = 6'h08; r_fn = 6'($urandom); end
        5:          begin r_op = 6'h09; r_fn = 6'($urandom); end
        6:          begin r_op = 6'h00; r_fn = 6'($urandom); end
        default:    begin r_op = 6'($urandom); r_fn = 6'($urandom); end
      endcase
      run_instr("rand", r_op, r_fn, $urandom_range(0, 3), 1'($urandom),
                ((n % 10) == 7) ? $urandom_range(1, 4) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
